// File: rtl/cpu_pkg.sv
// Shared widths, special register addresses and control-word layout for the 9-bit pipelined CPU.
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int CTRL_W = 8;

  localparam logic [ADDR_W-1:0] REG_ZERO = 4'b0000;
  localparam logic [ADDR_W-1:0] REG_SSB  = 4'b1000;

  // Control word bit layout; bit 7 is spare
  localparam int CTRL_WRITE_REG        = 0;
  localparam int CTRL_SPECIAL_OP       = 1;
  localparam int CTRL_SPECIAL_FUNC_LSB = 2;
  localparam int CTRL_SPECIAL_FUNC_W   = 3;
  localparam int CTRL_FULL_ADDR        = 5;
  localparam int LOAD_BIT              = 6;

  function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[LOAD_BIT];
  endfunction
endpackage

// File: rtl/wb_bypass.sv
// Write-back bypass for one operand: forwards wb_data when the write targets this source ($0 excluded).
module wb_bypass
  import cpu_pkg::*;
(
  input  logic [ADDR_W-1:0] i_src,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_wb_write,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_data
);
  logic w_hit;

  assign w_hit  = i_wb_write && (i_wb_addr == i_src) && (i_src != REG_ZERO);
  assign o_data = w_hit ? i_wb_data : i_data;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, stall/flush control and load-use hazard detection.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              id_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic [ADDR_W-1:0] id_src3,
  input  logic [ADDR_W-1:0] id_src4,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic [DATA_W-1:0] data4,
  input  logic [1:0]        aro,
  input  logic              ldst,
  input  logic              wb_write,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [ADDR_W-1:0] ex_dest,
  output logic [ADDR_W-1:0] ex_src1,
  output logic [ADDR_W-1:0] ex_src2,
  output logic [ADDR_W-1:0] ex_src3,
  output logic [ADDR_W-1:0] ex_src4,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [DATA_W-1:0] ex_data3,
  output logic [DATA_W-1:0] ex_data4,
  output logic [1:0]        ex_aro,
  output logic              ex_ldst,
  output logic              hazard_stall
);
  logic              r_ex_valid;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [ADDR_W-1:0] r_ex_dest;
  logic [ADDR_W-1:0] r_ex_src  [4];
  logic [DATA_W-1:0] r_ex_data [4];
  logic [1:0]        r_ex_aro;
  logic              r_ex_ldst;

  logic [ADDR_W-1:0] w_id_src   [4];
  logic [DATA_W-1:0] w_id_data  [4];
  logic [ADDR_W-1:0] w_byp_src  [4];
  logic [DATA_W-1:0] w_byp_in   [4];
  logic [DATA_W-1:0] w_byp_out  [4];
  logic              w_bubble;

  assign w_id_src  = '{id_src1, id_src2, id_src3, id_src4};
  assign w_id_data = '{data1, data2, data3, data4};

  // While stalled the bypass watches the held EX sources; an invalid EX is steered to $0 so it never updates
  for (genvar n = 0; n < 4; n++) begin : g_byp
    assign w_byp_src[n] = stall ? (r_ex_valid ? r_ex_src[n] : REG_ZERO) : w_id_src[n];
    assign w_byp_in[n]  = stall ? r_ex_data[n] : w_id_data[n];

    wb_bypass u_wb_bypass (
      .i_src      (w_byp_src[n]),
      .i_data     (w_byp_in[n]),
      .i_wb_write (wb_write),
      .i_wb_addr  (wb_addr),
      .i_wb_data  (wb_data),
      .o_data     (w_byp_out[n])
    );
  end

  assign w_bubble = flush || (!stall && !id_valid);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N || w_bubble) begin
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= '0;
      r_ex_dest  <= '0;
      r_ex_aro   <= '0;
      r_ex_ldst  <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        r_ex_src[n]  <= '0;
        r_ex_data[n] <= '0;
      end
    end else if (stall) begin
      for (int n = 0; n < 4; n++) r_ex_data[n] <= w_byp_out[n];
    end else begin
      r_ex_valid <= 1'b1;
      r_ex_ctrl  <= id_ctrl;
      r_ex_dest  <= id_dest;
      r_ex_aro   <= aro;
      r_ex_ldst  <= ldst;
      for (int n = 0; n < 4; n++) begin
        r_ex_src[n]  <= w_id_src[n];
        r_ex_data[n] <= w_byp_out[n];
      end
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_ctrl  = r_ex_ctrl;
  assign ex_dest  = r_ex_dest;
  assign ex_src1  = r_ex_src[0];
  assign ex_src2  = r_ex_src[1];
  assign ex_src3  = r_ex_src[2];
  assign ex_src4  = r_ex_src[3];
  assign ex_data1 = r_ex_data[0];
  assign ex_data2 = r_ex_data[1];
  assign ex_data3 = r_ex_data[2];
  assign ex_data4 = r_ex_data[3];
  assign ex_aro   = r_ex_aro;
  assign ex_ldst  = r_ex_ldst;

  // Load-use: a load in EX whose result is needed by ID's first two operands
  assign hazard_stall = r_ex_valid && ctrl_is_load(r_ex_ctrl) && (r_ex_dest != REG_ZERO) &&
                        id_valid && ((r_ex_dest == id_src1) || (r_ex_dest == id_src2));
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomised bench for id_ex_stage; expected EX contents are queued at drive time and popped after each edge.
module tb_id_ex_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic            valid;
    logic [7:0]      ctrl;
    logic [3:0]      dest;
    logic [3:0][3:0] src;
    logic [3:0][7:0] data;
    logic [1:0]      aro;
    logic            ldst;
  } ex_t;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic id_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [7:0] id_ctrl = '0;
  logic [3:0] id_dest = '0;
  logic [3:0][3:0] src = '0;
  logic [3:0][7:0] din = '0;
  logic [1:0] aro = '0;
  logic ldst = 1'b0;
  logic wb_write = 1'b0;
  logic [3:0] wb_addr = '0;
  logic [7:0] wb_data = '0;

  logic ex_valid, ex_ldst, hazard_stall;
  logic [7:0] ex_ctrl, ex_data1, ex_data2, ex_data3, ex_data4;
  logic [3:0] ex_dest, ex_src1, ex_src2, ex_src3, ex_src4;
  logic [1:0] ex_aro;

  ex_t m;
  ex_t q[$];
  int errors = 0;
  int checks = 0;

  id_ex_stage dut (
    .CLK(CLK), .RESET_N(RESET_N), .id_valid(id_valid), .stall(stall), .flush(flush),
    .id_ctrl(id_ctrl), .id_dest(id_dest),
    .id_src1(src[0]), .id_src2(src[1]), .id_src3(src[2]), .id_src4(src[3]),
    .data1(din[0]), .data2(din[1]), .data3(din[2]), .data4(din[3]),
    .aro(aro), .ldst(ldst), .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_dest(ex_dest),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_src3(ex_src3), .ex_src4(ex_src4),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_data3(ex_data3), .ex_data4(ex_data4),
    .ex_aro(ex_aro), .ex_ldst(ex_ldst), .hazard_stall(hazard_stall)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge applied to the model state
  task automatic model_edge();
    if (flush || (!stall && !id_valid)) begin
      m = '0;
    end else if (stall) begin
      for (int n = 0; n < 4; n++)
        if (wb_write && m.valid && wb_addr == m.src[n] && m.src[n] != 4'b0000)
          m.data[n] = wb_data;
    end else begin
      m.valid = 1'b1;
      m.ctrl  = id_ctrl;
      m.dest  = id_dest;
      m.src   = src;
      m.aro   = aro;
      m.ldst  = ldst;
      for (int n = 0; n < 4; n++)
        m.data[n] = (wb_write && wb_addr == src[n] && src[n] != 4'b0000) ? wb_data : din[n];
    end
  endtask

  task automatic compare_out(input string tag);
    ex_t e;
    logic hz;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_valid"}, ex_valid, e.valid);
    chk({tag, "_ctrl"},  ex_ctrl,  e.ctrl);
    chk({tag, "_dest"},  ex_dest,  e.dest);
    chk({tag, "_src"},   {ex_src4, ex_src3, ex_src2, ex_src1}, e.src);
    chk({tag, "_data1"}, ex_data1, e.data[0]);
    chk({tag, "_data2"}, ex_data2, e.data[1]);
    chk({tag, "_data3"}, ex_data3, e.data[2]);
    chk({tag, "_data4"}, ex_data4, e.data[3]);
    chk({tag, "_aro"},   ex_aro,   e.aro);
    chk({tag, "_ldst"},  ex_ldst,  e.ldst);
    hz = e.valid && e.ctrl[6] && e.dest != 4'b0000 && id_valid && (e.dest == src[0] || e.dest == src[1]);
    chk({tag, "_hazard"}, hazard_stall, hz);
  endtask

  task automatic step(input string tag);
    model_edge();
    q.push_back(m);
    @(posedge CLK);
    #1;
    compare_out(tag);
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; stall = 1'b0; flush = 1'b0; wb_write = 1'b0;
    id_ctrl = '0; id_dest = '0; src = '0; din = '0; aro = '0; ldst = 1'b0;
    wb_addr = '0; wb_data = '0;
  endtask

  task automatic load(input logic [7:0] c, input logic [3:0] d,
                      input logic [3:0][3:0] s, input logic [3:0][7:0] v);
    id_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    id_ctrl = c; id_dest = d; src = s; din = v;
  endtask

  initial begin
    m = '0;
    idle_inputs();

    // Reset held for two cycles
    repeat (2) @(posedge CLK);
    #1;
    q.push_back(m);
    compare_out("reset");
    chk("reset_hazard", hazard_stall, 1'b0);

    // First load after release
    RESET_N = 1'b1;
    load(8'h05, 4'h3, {4'h4, 4'h3, 4'h2, 4'h1}, {8'h44, 8'h33, 8'h22, 8'h19});
    aro = 2'b01;
    step("first_load");
    chk("first_data1", ex_data1, 8'h19);
    chk("first_valid", ex_valid, 1'b1);

    // Same-cycle bypass, then no bypass of $0
    load(8'h01, 4'h2, {4'h0, 4'h0, 4'h0, 4'b1001}, {8'h0, 8'h0, 8'h0, 8'd2});
    wb_write = 1'b1; wb_addr = 4'b1001; wb_data = 8'd25;
    step("byp_hit");
    chk("byp_hit_data1", ex_data1, 8'd25);
    load(8'h01, 4'h2, {4'h0, 4'h0, 4'h0, 4'b0000}, {8'h0, 8'h0, 8'h0, 8'd0});
    wb_addr = 4'b0000;
    step("byp_zero");
    chk("byp_zero_data1", ex_data1, 8'd0);
    wb_write = 1'b0;

    // Stall tracking on operand 2
    load(8'h03, 4'h5, {4'h1, 4'h2, 4'b0111, 4'h3}, {8'h0A, 8'h0B, 8'd1, 8'h0C});
    step("stall_load");
    stall = 1'b1;
    load(8'hAA, 4'hF, {4'hF, 4'hF, 4'hF, 4'hF}, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
    stall = 1'b1;
    step("stall_c1");
    chk("stall_c1_data2", ex_data2, 8'd1);
    wb_write = 1'b1; wb_addr = 4'b0111; wb_data = 8'd22;
    step("stall_c2");
    chk("stall_c2_data2", ex_data2, 8'd22);
    wb_write = 1'b0;
    step("stall_c3");
    chk("stall_c3_data2", ex_data2, 8'd22);
    chk("stall_c3_ctrl", ex_ctrl, 8'h03);

    // Flush beats stall
    flush = 1'b1;
    step("flush_stall");
    chk("flush_valid", ex_valid, 1'b0);
    chk("flush_ctrl", ex_ctrl, 8'h00);

    // Load-use hazard
    load(8'h40, 4'b1110, {4'h0, 4'h0, 4'h0, 4'h0}, '0);
    step("ld_use_load");
    load(8'h01, 4'h1, {4'h0, 4'h0, 4'b1110, 4'h2}, '0);
    #1;
    chk("hazard_src2", hazard_stall, 1'b1);
    src[1] = 4'b0101;
    #1;
    chk("hazard_nomatch", hazard_stall, 1'b0);
    id_valid = 1'b0;
    src[0] = 4'b1110;
    #1;
    chk("hazard_id_invalid", hazard_stall, 1'b0);
    load(8'h40, 4'b0000, '0, '0);
    step("ld_dest_zero");
    #1;
    chk("hazard_dest_zero", hazard_stall, 1'b0);

    // Special-op operands with one bypassed, ssb write not affecting aro/ldst
    load(8'h0A, 4'b1000, {4'b1111, 4'b0110, 4'b0111, 4'b1110}, {8'd3, 8'd2, 8'd1, 8'd4});
    aro = 2'b10; ldst = 1'b1;
    wb_write = 1'b1; wb_addr = 4'b0110; wb_data = 8'd9;
    step("special");
    chk("special_data", {ex_data4, ex_data3, ex_data2, ex_data1}, {8'd3, 8'd9, 8'd1, 8'd4});
    chk("special_aro", ex_aro, 2'b10);
    chk("special_ldst", ex_ldst, 1'b1);
    wb_addr = 4'b1000; wb_data = 8'h7F; aro = 2'b01; ldst = 1'b0;
    step("ssb_write");
    chk("ssb_aro", ex_aro, 2'b01);
    wb_write = 1'b0;

    // Bubble via id_valid=0
    id_valid = 1'b0;
    step("bubble");

    // Reset asserted mid-stall clears immediately
    load(8'h41, 4'h6, {4'h1, 4'h2, 4'h3, 4'h4}, {8'h11, 8'h22, 8'h33, 8'h44});
    step("pre_reset");
    stall = 1'b1;
    step("reset_stall");
    #2;
    RESET_N = 1'b0;
    #1;
    m = '0;
    q.push_back(m);
    compare_out("async_reset");
    idle_inputs();
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      id_valid = ($urandom_range(0, 9) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      id_ctrl  = 8'($urandom);
      id_dest  = 4'($urandom_range(0, 3));
      for (int n = 0; n < 4; n++) begin
        src[n] = 4'($urandom_range(0, 3));
        din[n] = 8'($urandom);
      end
      aro      = 2'($urandom);
      ldst     = 1'($urandom);
      wb_write = 1'($urandom);
      wb_addr  = 4'($urandom_range(0, 3));
      wb_data  = 8'($urandom);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 9-bit pipelined CPU. Sits directly downstream of register_file.
- Captures register_file's four read ports, aro and ldst, together with the decoded control word, destination and source full addresses.
- Applies write-back bypass so same-cycle and stall-time writes are not lost.
- Supports stall (hold), flush (bubble) and load-use hazard detection for the ID stage.

Parameters:
DATA_W, 8, register/operand width
ADDR_W, 4, full register address width (bank bit + 3-bit index)
CTRL_W, 8, decoded control word width; bit LOAD_BIT marks a load

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET_N  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
stall  in  1  hold EX register contents
flush  in  1  replace next EX contents with a bubble
id_ctrl  in  CTRL_W  decoded control word
id_dest  in  ADDR_W  destination full address
id_src1..id_src4  in  ADDR_W each  full addresses driving data1..data4
data1..data4  in  DATA_W each  register_file read data
aro  in  2  register_file aro
ldst  in  1  register_file ldst
wb_write  in  1  write-back enable (same strobe as register_file write_reg)
wb_addr  in  ADDR_W  write-back full address
wb_data  in  DATA_W  write-back data
ex_valid  out  1  EX holds a real instruction
ex_ctrl  out  CTRL_W  registered control
ex_dest  out  ADDR_W  registered destination
ex_src1..ex_src4  out  ADDR_W each  registered source addresses
ex_data1..ex_data4  out  DATA_W each  registered (bypassed) operands
ex_aro  out  2  registered aro
ex_ldst  out  1  registered ldst
hazard_stall  out  1  combinational load-use request to ID/IF

Behaviour:
- Reset (RESET_N low, asynchronous): every registered output is 0, including ex_valid.
  - hazard_stall is 0 while ex_valid is 0.
  - Release is synchronous to the next CLK edge.
- Priority at each edge: reset > flush > stall > load.
- Flush: ex_valid <= 0 and ex_ctrl <= 0. Data, address and aro/ldst fields are also cleared to 0.
- Load (stall=0, flush=0):
  - ex_valid <= id_valid.
  - All fields are captured with latency 1 cycle.
  - id_valid=0 loads a bubble, which is identical to a flush.
- Bypass on load, per operand n:
  - If wb_write=1, wb_addr==id_srcn and id_srcn != 0000, ex_datan <= wb_data.
  - Otherwise ex_datan <= datan.
  - This covers the register_file read returning the pre-write value on the write edge.
- Stall (stall=1, flush=0):
  - All fields hold.
  - Exception: if wb_write=1, wb_addr==ex_srcn, ex_srcn != 0000 and ex_valid=1, then ex_datan <= wb_data. Held operands therefore track writes made during the stall.
- Address 0000 ($0) is never bypassed; its operand stays as read.
- aro/ldst are never bypassed, even when wb_addr addresses the ssb register (1000). A write to ssb during the cycle is visible in EX only from the following instruction.
- hazard_stall = ex_valid & ex_ctrl[LOAD_BIT] & (ex_dest != 0000) & id_valid & (ex_dest matches id_src1 or id_src2).
  - Purely combinational; no registered delay.
  - The consumer asserts stall/flush accordingly. This block does not self-stall.
- Simultaneous stall and flush: flush wins and produces a bubble.
- Reset mid-stall: all outputs clear immediately; no held state survives.

Decomposition:
- Package cpu_pkg holds:
  - DATA_W, ADDR_W, CTRL_W
  - REG_ZERO = 4'b0000, REG_SSB = 4'b1000
  - LOAD_BIT index
  - ctrl word field offsets (write_reg, special_op, special_func[2:0], full_addr)
- One sub-module, wb_bypass: compare + mux for a single operand, instantiated 4x.
  - Inputs: src, data, wb_write, wb_addr, wb_data.
  - Output: the selected data.

Test Plan:
- Reset then release: after RESET_N=0 for 2 cycles, all ex_* outputs are 0 and hazard_stall=0; the first load with id_valid=1, data1=8'h19 gives ex_data1=8'h19 and ex_valid=1 one edge later.
- Same-cycle bypass: id_src1=4'b1001, data1=2, wb_write=1, wb_addr=4'b1001, wb_data=25 -> ex_data1=25; with wb_addr=4'b0000 and id_src1=0000, data1=0 -> ex_data1=0 (no bypass of $0).
- Stall tracking: load with ex_src2=4'b0111, ex_data2=1; hold stall=1 for 3 cycles and write wb_addr=0111, wb_data=22 in cycle 2 -> ex_data2=22 from cycle 3, all other fields unchanged throughout.
- Flush vs stall: stall=1 and flush=1 on the same edge with valid EX contents -> ex_valid=0 and ex_ctrl=0 next cycle.
- Load-use hazard: EX holds a load (ctrl LOAD_BIT=1) with ex_dest=4'b1110; ID has id_valid=1, id_src2=4'b1110 -> hazard_stall=1 in the same cycle. With ex_dest=0000 -> hazard_stall=0.
- Special-op operands: id_src1..4 = 1110, 0111, 0110, 1111 with data 4, 1, 2, 3 and wb_write=1, wb_addr=0110, wb_data=9 -> ex_data1..4 = 4, 1, 9, 3; ex_aro and ex_ldst match the inputs.
